// File: rtl/hazard_control_unit_if.sv
// Hazard-control bus: pipeline-side register/handshake observations in,
// per-stage enables, flushes, forward selects and performance status out.
interface hazard_control_unit_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       idex_rd;
   logic             idex_mem_read;
   logic [4:0]       exmem_rd;
   logic             exmem_reg_write;
   logic [4:0]       memwb_rd;
   logic             memwb_reg_write;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic             mem_timeout;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
             idex_rd, idex_mem_read, exmem_rd, exmem_reg_write,
             memwb_rd, memwb_reg_write, ex_branch_taken, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
             idex_flush, fwd_a, fwd_b, stall_cycles, flush_count, mem_timeout
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
             idex_rd, idex_mem_read, exmem_rd, exmem_reg_write,
             memwb_rd, memwb_reg_write, ex_branch_taken, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
             idex_flush, fwd_a, fwd_b, stall_cycles, flush_count, mem_timeout
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush/forwarding controller for a 5-stage RISC-V pipeline, with
// saturating stall/flush counters and a sticky data-memory timeout flag.
module hazard_control_unit #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input logic                   clk,
   input logic                   rst,
   hazard_control_unit_if.slave  bus
);
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0]       TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);
   localparam logic [7:0]       WAIT_MAX   = 8'hFF;
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [7:0]       wait_cnt_r;
   logic [CNT_W-1:0] stall_cycles_r;
   logic [CNT_W-1:0] flush_count_r;
   logic             mem_timeout_r;

   logic       freeze_s;
   logic       load_use_s;
   logic       branch_s;
   logic       pc_en_s;
   logic       ifid_en_s;
   logic       idex_en_s;
   logic       exmem_en_s;
   logic       memwb_en_s;
   logic       ifid_flush_s;
   logic       idex_flush_s;
   logic [1:0] fwd_a_s;
   logic [1:0] fwd_b_s;

   // EX/MEM result is younger than MEM/WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] exmem_rd,
      input logic       exmem_wr,
      input logic [4:0] memwb_rd,
      input logic       memwb_wr
   );
      logic [1:0] sel;
      if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
         sel = 2'b10;
      end else if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard condition decode from the current pipeline contents.
   always_comb begin
      freeze_s   = bus.mem_req & ~bus.mem_ready;
      load_use_s = bus.idex_mem_read & (bus.idex_rd != 5'd0) &
                   ((bus.id_use_rs1 & (bus.id_rs1 == bus.idex_rd)) |
                    (bus.id_use_rs2 & (bus.id_rs2 == bus.idex_rd)));
      branch_s   = bus.ex_branch_taken;
   end

   // Prioritised enable/flush generation; a frozen pipeline keeps pending hazards intact.
   always_comb begin
      pc_en_s      = 1'b1;
      ifid_en_s    = 1'b1;
      idex_en_s    = 1'b1;
      exmem_en_s   = 1'b1;
      memwb_en_s   = 1'b1;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b0;
      fwd_a_s      = 2'b00;
      fwd_b_s      = 2'b00;
      if (rst) begin
         pc_en_s      = 1'b0;
         ifid_en_s    = 1'b0;
         idex_en_s    = 1'b0;
         exmem_en_s   = 1'b0;
         memwb_en_s   = 1'b0;
         ifid_flush_s = 1'b1;
         idex_flush_s = 1'b1;
      end else begin
         fwd_a_s = fwd_sel(bus.ex_rs1, bus.exmem_rd, bus.exmem_reg_write,
                           bus.memwb_rd, bus.memwb_reg_write);
         fwd_b_s = fwd_sel(bus.ex_rs2, bus.exmem_rd, bus.exmem_reg_write,
                           bus.memwb_rd, bus.memwb_reg_write);
         if (freeze_s) begin
            pc_en_s    = 1'b0;
            ifid_en_s  = 1'b0;
            idex_en_s  = 1'b0;
            exmem_en_s = 1'b0;
            memwb_en_s = 1'b0;
         end else if (branch_s) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
         end else if (load_use_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
         end else begin
            pc_en_s = 1'b1;
         end
      end
   end

   // Memory-wait FSM, timeout detection and saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= RUN;
         wait_cnt_r     <= 8'd0;
         stall_cycles_r <= {CNT_W{1'b0}};
         flush_count_r  <= {CNT_W{1'b0}};
         mem_timeout_r  <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (freeze_s) begin
                  state_r    <= MEM_WAIT;
                  wait_cnt_r <= 8'd1;
               end else begin
                  state_r    <= RUN;
                  wait_cnt_r <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (freeze_s) begin
                  state_r <= MEM_WAIT;
                  if (wait_cnt_r != WAIT_MAX) begin
                     wait_cnt_r <= wait_cnt_r + 8'd1;
                  end else begin
                     wait_cnt_r <= wait_cnt_r;
                  end
                  if (wait_cnt_r == TIMEOUT_M1) begin
                     mem_timeout_r <= 1'b1;
                  end else begin
                     mem_timeout_r <= mem_timeout_r;
                  end
               end else begin
                  // Either the access completed or the request was withdrawn.
                  state_r    <= RUN;
                  wait_cnt_r <= 8'd0;
               end
            end
            default: begin
               state_r    <= RUN;
               wait_cnt_r <= 8'd0;
            end
         endcase

         if (!pc_en_s && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + CNT_ONE;
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end

         if (branch_s && !freeze_s && (flush_count_r != CNT_MAX)) begin
            flush_count_r <= flush_count_r + CNT_ONE;
         end else begin
            flush_count_r <= flush_count_r;
         end
      end
   end

   assign bus.pc_en        = pc_en_s;
   assign bus.ifid_en      = ifid_en_s;
   assign bus.idex_en      = idex_en_s;
   assign bus.exmem_en     = exmem_en_s;
   assign bus.memwb_en     = memwb_en_s;
   assign bus.ifid_flush   = ifid_flush_s;
   assign bus.idex_flush   = idex_flush_s;
   assign bus.fwd_a        = fwd_a_s;
   assign bus.fwd_b        = fwd_b_s;
   assign bus.stall_cycles = stall_cycles_r;
   assign bus.flush_count  = flush_count_r;
   assign bus.mem_timeout  = mem_timeout_r;
endmodule
